// File: rtl/display_pkg.sv
// display_pkg: constants shared by the display blocks.
//   state_e   : scan FSM states (IDLE, BLANK, SHOW)
//   SEG_OFF   : active-low segment pattern with every segment dark
//   SEG_TABLE : 16-entry BCD -> {g,f,e,d,c,b,a} active-low table; codes
//               10..15 decode to all-dark so they can blank leading zeros
//   seg_decode: table lookup helper
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    return SEG_TABLE[bcd];
  endfunction

endpackage

// File: rtl/display_scan_edge_sync.sv
// edge_sync: three-flop synchronizer for an asynchronous level plus a
// rising-edge detector producing a single-cycle pulse.
//   clk      : system clock
//   reset    : synchronous, active-high; clears the synchronizer
//   async_in : asynchronous input level
//   rise     : one-cycle pulse, high the cycle after the edge reaches stage 2
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3
  logic [2:0] sync_q;
  // vld_q[i] marks that sync_q[i] holds a real sample rather than its reset
  // value; without it an input already high across reset would look like a
  // fresh 0->1 edge once the zeros flush out.
  logic [2:0] vld_q;

  // Synchronizer shift chain and its sample-valid shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 3'b000;
      vld_q  <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      vld_q  <= {vld_q[1:0], 1'b1};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2] & vld_q[2];

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed common-anode 7-segment driver.
// Each rising edge of slow_clk (synchronized) steps to the next digit, with a
// BLANK_CYCLES all-dark gap before each digit is lit. The BCD word is
// snapshotted at the start of every frame.
//   clk, reset  : system clock, synchronous active-high reset
//   slow_clk    : divided scan clock, asynchronous to clk
//   enable      : 1 = scan, 0 = display dark
//   digits      : NUM_DIGITS BCD nibbles, digit 0 in bits [3:0] (rightmost)
//   seg         : active-low segments {g,f,e,d,c,b,a} (registered)
//   an          : active-low digit selects, at most one low (registered)
//   frame_start : one-cycle pulse when the snapshot is taken (registered)
module display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    slow_clk,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

  logic                    tick;
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;
  logic [3:0]              digit_d;

  edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (slow_clk),
    .rise     (tick)
  );

  // Next-state logic: scan FSM, blank counter, digit index and snapshot
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    fs_d    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = CNT_LOAD;
            snap_d  = digits;
            fs_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // Ticks arriving here are intentionally ignored.
        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_d = ST_SHOW;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (tick) begin
            state_d = ST_BLANK;
            cnt_d   = CNT_LOAD;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              snap_d = digits;
              fs_d   = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            state_d = ST_SHOW;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output decode from next-state values so the registered outputs line up
  // with the state register (BLANK already presents the upcoming digit's seg).
  always_comb begin
    digit_d = snap_d[{idx_d, 2'b00} +: 4];
    an_d    = '1;
    if (state_d == ST_IDLE) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = seg_decode(digit_d);
    end
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
    end else begin
      an_d = '1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= '1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fs_q    <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed scenarios followed by randomized stimulus, every
// cycle compared against a behavioural model of the scan display.
module tb_display_scan;

  localparam int ND = 4;
  localparam int BC = 4;
  localparam int DARK = 0;
  localparam int GAP  = 1;
  localparam int LIT  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        slow_clk;
  logic        enable;
  logic [15:0] digits;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  always #5 clk = ~clk;

  display_scan #(.NUM_DIGITS(ND), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .reset       (reset),
    .slow_clk    (slow_clk),
    .enable      (enable),
    .digits      (digits),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  int n_vec = 0;
  int n_bad = 0;
  int ph = 0;

  // behavioural model
  bit          smp[$];   // slow_clk samples taken since the last reset
  int          mode;
  int          gap_left;
  int          pos;
  logic [15:0] frame;
  bit          fs_exp;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One clock edge of the display as seen from outside: a scan tick exists
  // when the slow clock rose two samples ago (and the synchronizer has seen
  // three real samples since reset).
  task automatic model_edge();
    bit tk;
    int n;
    fs_exp = 1'b0;
    if (reset) begin
      smp.delete();
      mode = DARK;
      pos = 0;
      frame = 16'h0000;
      return;
    end
    n = smp.size();
    tk = (n >= 3) && smp[n-2] && !smp[n-3];
    smp.push_back(slow_clk);
    if (smp.size() > 4) void'(smp.pop_front());
    if (!enable) begin
      mode = DARK;
      pos = 0;
    end else if (mode == DARK) begin
      if (tk) begin
        mode = GAP; gap_left = BC; pos = 0; frame = digits; fs_exp = 1'b1;
      end
    end else if (mode == GAP) begin
      if (gap_left == 1) mode = LIT;
      else gap_left--;
    end else if (tk) begin
      mode = GAP;
      gap_left = BC;
      if (pos == ND - 1) begin
        pos = 0; frame = digits; fs_exp = 1'b1;
      end else begin
        pos++;
      end
    end
  endtask

  function automatic logic [6:0] exp_seg();
    if (mode == DARK) return 7'h7F;
    return dec(frame[4*pos +: 4]);
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one;
    one = 4'b0001;
    if (mode == LIT) return ~(one << pos);
    return 4'b1111;
  endfunction

  // g: 0 = regular square wave, 1 = force low, 2 = force high (next sample)
  task automatic step(input int g);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("seg", 16'(seg), 16'(exp_seg()));
    check_eq("an", 16'(an), 16'(exp_an()));
    check_eq("frame_start", 16'(frame_start), 16'(fs_exp));
    ph = (ph + 1) % 16;
    slow_clk = (g == 1) ? 1'b0 : (g == 2) ? 1'b1 : (ph >= 8);
  endtask

  initial begin
    int k;
    int off_left;
    logic [3:0] prev_an;
    reset = 1'b1; enable = 1'b0; digits = 16'h0000; slow_clk = 1'b0;
    step(0);
    step(0);
    check_eq("rst_seg", 16'(seg), 16'h007F);
    check_eq("rst_an", 16'(an), 16'h000F);
    check_eq("rst_fs", 16'(frame_start), 16'h0000);

    // first frame of 4321, then change to 9999 while digit 2 is lit
    reset = 1'b0; enable = 1'b1; digits = 16'h4321;
    for (k = 0; k < 200 && an !== 4'b1011; k++) step(0);
    check_eq("reach_idx2", 16'(an), 16'h000B);
    digits = 16'h9999;
    for (int i = 0; i < 150; i++) step(0);

    // leading-zero suppression codes
    digits = 16'hFF05;
    for (int i = 0; i < 140; i++) step(0);

    // drop enable while a digit is lit, then re-enable
    for (k = 0; k < 200 && an === 4'b1111; k++) step(0);
    check_eq("reach_show", 16'(an != 4'b1111), 16'h0001);
    enable = 1'b0;
    step(0);
    check_eq("dis_an", 16'(an), 16'h000F);
    check_eq("dis_seg", 16'(seg), 16'h007F);
    for (int i = 0; i < 5; i++) step(0);
    enable = 1'b1;
    for (int i = 0; i < 80; i++) step(0);

    // reset for one cycle mid-BLANK while slow_clk is high
    for (k = 0; k < 200 && !(an === 4'b1111 && seg !== 7'h7F && slow_clk); k++) step(0);
    check_eq("reach_blank", 16'(an === 4'b1111 && seg !== 7'h7F), 16'h0001);
    reset = 1'b1;
    step(0);
    check_eq("mid_rst_seg", 16'(seg), 16'h007F);
    check_eq("mid_rst_an", 16'(an), 16'h000F);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) step(0);

    // a one-cycle dip of slow_clk right after entering BLANK from SHOW makes
    // a second rising edge whose tick lands inside BLANK
    prev_an = an;
    for (k = 0; k < 300 && !(prev_an !== 4'b1111 && an === 4'b1111); k++) begin
      prev_an = an;
      step(0);
    end
    check_eq("reach_gap", 16'(an), 16'h000F);
    step(1);
    for (int i = 0; i < 80; i++) step(0);

    // randomized phase
    off_left = 0;
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (off_left > 0) begin
        off_left--;
        enable = (off_left == 0);
      end else if ($urandom_range(0, 149) == 0) begin
        off_left = $urandom_range(1, 20);
        enable = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) digits = 16'($urandom);
      case ($urandom_range(0, 59))
        0: step(1);
        1: step(2);
        default: step(0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed 7-segment display driver that sits directly downstream of the ripple frequency divider. Samples the divider's slow square-wave output in the system clock domain, turns each rising edge into a one-cycle scan tick, and on each tick steps to the next digit of a common-anode multi-digit display. Between digits it inserts a programmable blanking gap to suppress ghosting. Each new frame takes a coherent snapshot of the BCD input word.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (≥2).
- BLANK_CYCLES, 4: clk cycles with all digits off between consecutive digits (≥1).

- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- slow_clk  in  1  divided clock from the divider, treated as asynchronous data.
- enable  in  1  1 = scan, 0 = display dark.
- digits  in  4*NUM_DIGITS  BCD values; digit i = digits[4i+3:4i], digit 0 is rightmost.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- an  out  NUM_DIGITS  active-low digit selects; at most one bit is 0.
- frame_start  out  1  one-cycle pulse when a snapshot is taken.

## Operation
- Synchronizer: three flops s1→s2→s3 on slow_clk. tick = s2 & ~s3, combinational, at most one cycle per slow_clk period.
- FSM states:
  - IDLE: an all 1, seg 7'h7F.
  - BLANK: an all 1, seg holds the decoded value for the next digit.
  - SHOW: an[idx]=0, seg = decode(snapshot digit idx).
- Transitions:
  - Any state with enable=0 → IDLE next cycle; idx←0.
  - IDLE with enable=1 and tick → BLANK; idx←0; snapshot←digits; frame_start=1.
  - SHOW with tick → BLANK; idx←idx+1. If the old idx was NUM_DIGITS-1, idx wraps to 0, snapshot←digits and frame_start=1.
  - BLANK: the counter loads BLANK_CYCLES-1 on entry and decrements each cycle. At 0 → SHOW.
- Tick during BLANK is dropped; no state change. Integration requires BLANK_CYCLES < slow_clk period in clk cycles.
- Decode:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000.
  - 10–15 → 1111111 (blank; used for leading-zero suppression).
- idx width is max(1, clog2(NUM_DIGITS)). idx never exceeds NUM_DIGITS-1.
- digits changes mid-frame have no effect until the next snapshot.

## Timing
- Reset values: state IDLE, idx 0, snapshot 0, s1/s2/s3 0, seg 7'h7F, an all 1, frame_start 0.
- Latency from slow_clk rising edge (set up before clk edge k) to tick: tick is high during cycle k+2.
- From the tick cycle to state BLANK: next edge.
- an for the new digit goes low BLANK_CYCLES cycles after entering BLANK.
- All outputs are registered; no combinational path from inputs to outputs.
- frame_start is asserted in the same cycle that the state first reads BLANK with idx 0.
- Reset asserted mid-scan: all outputs reach their reset values at the next edge. The synchronizer clears, so a slow_clk already high produces no tick until its next rising edge.
- enable and tick in the same cycle: enable=0 wins.

## Structure
- Shared package display_pkg holds:
  - the state enum (IDLE, BLANK, SHOW);
  - SEG_OFF = 7'h7F;
  - the 16-entry BCD→segment constant table, shared with other display blocks.
- Sub-module edge_sync: the 3-flop synchronizer plus rising-edge detector, with ports clk, reset, async_in, rise.
- Decode, FSM, blank counter and snapshot register live in display_scan.

## Test plan
All scenarios use NUM_DIGITS=4 and BLANK_CYCLES=4; slow_clk is a 16-cycle-period square wave.

- Reset then enable=1, digits=16'h4321:
  - First frame_start 3 cycles after slow_clk rises.
  - an sequence 1110, 1101, 1011, 0111 with seg 1111001, 0100100, 0110000, 0011001.
  - Each digit is preceded by 4 cycles of an=1111.
- Change digits to 16'h9999 while idx=2:
  - Digits 2 and 3 still show 3 and 4.
  - The next frame shows 9 on all digits; frame_start pulses once per frame (every 64 cycles).
- digits=16'hFF05: digit 3 and digit 2 show seg 1111111 while selected; digit 0 shows 0010010 and digit 1 shows 1000000.
- Drop enable during SHOW: next cycle an=1111 and seg=7'h7F. Re-enable: restarts at idx 0 with frame_start.
- Assert reset for 1 cycle mid-BLANK with slow_clk high: all outputs reach reset values next edge; no tick until the following slow_clk rise.
- Glitch slow_clk high for 1 cycle inside BLANK: the tick is dropped; the idx sequence is unchanged.
